// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS fetch stage owning the PC, fetching over req/ack and committing next PC on retire
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump_f,
    input  logic        branch_f,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_cnt
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic        retire;

    assign retire      = (state == HOLD) && instr_ready;
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // Next state: IDLE leaves immediately, FETCH waits for ack, HOLD waits for retire
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = imem_ack ? HOLD : FETCH;
            HOLD:    state_nxt = instr_ready ? FETCH : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // Next PC: jump beats taken branch beats fall-through
    always_comb begin
        pc_nxt = jump_f              ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                 (branch_f && zero)  ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                                       pc_plus4;
    end

    // Instruction capture on ack, PC commit and retire count on retirement
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= 32'd0;
            retire_cnt <= 32'd0;
        end else begin
            if (state == FETCH && imem_ack) instr <= imem_rdata;
            if (retire) begin
                pc         <= pc_nxt;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench for instr_fetch_unit against a next-PC reference model
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump_f = 1'b0;
    logic        branch_f = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retire_cnt;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] mpc;
    logic [31:0] mcnt;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_f(jump_f),
        .branch_f(branch_f), .zero(zero), .pc(pc), .pc_plus4(pc_plus4),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference: next PC straight from the architectural rules
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic j, input logic b, input logic z);
        logic [31:0] p4;
        int          off;
        p4  = p + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (j) return {p4[31:28], w[25:0], 2'b00};
        if (b && z) return p4 + 32'(off);
        return p4;
    endfunction

    // One fetch/retire; called at a falling edge while in FETCH, returns at a falling edge back in FETCH
    task automatic do_instr(input int aw, input int rw, input logic [31:0] w,
                            input logic j, input logic b, input logic z);
        imem_ack = 1'b0;
        repeat (aw) begin
            imem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
        end
        imem_rdata = w;
        imem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        imem_rdata = $urandom;
        repeat (rw) begin
            imem_ack = 1'($urandom);
            jump_f = 1'($urandom); branch_f = 1'($urandom); zero = 1'($urandom);
            @(posedge clk); @(negedge clk);
        end
        imem_ack = 1'b0;
        jump_f = j; branch_f = b; zero = z; instr_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_ready = 1'b0; jump_f = 1'b0; branch_f = 1'b0; zero = 1'b0;
        mpc = model_next(mpc, w, j, b, z);
        mcnt = mcnt + 32'd1;
    endtask

    task automatic do_reset();
        imem_ack = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mpc = 32'd0; mcnt = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'd0); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'd0); end
        checks++; if (pc_plus4 !== 32'd4) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'd4); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (retire_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", retire_cnt); end
        rst_n = 1'b1;
        mpc = 32'd0; mcnt = 32'd0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_sequential();
        int          prev;
        logic [31:0] w;
        prev = cyc;
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_addr !== 32'(4 * i) || imem_addr !== mpc) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
            if (i > 0) begin
                checks++; if (cyc - prev !== 2) begin failures++; $display("FAIL seq_spacing%0d got=%0d exp=2", i, cyc - prev); end
            end
            prev = cyc;
            w = $urandom;
            do_instr(0, 0, w, 1'b0, 1'b0, 1'b0);
            checks++; if (instr !== w) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", i, instr, w); end
        end
        checks++; if (retire_cnt !== 32'd4) begin failures++; $display("FAIL seq_cnt got=%0d exp=4", retire_cnt); end
    endtask

    task automatic test_branch();
        do_instr(0, 0, {6'h02, 26'h000_0010}, 1'b1, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL br_setup got=%h exp=%h", imem_addr, 32'h40); end
        do_instr(0, 1, {16'h1000, 16'hFFFE}, 1'b0, 1'b1, 1'b1);
        checks++; if (imem_addr !== 32'h3C || mpc !== 32'h3C) begin failures++; $display("FAIL br_taken got=%h exp=%h", imem_addr, 32'h3C); end
        do_instr(0, 0, {6'h02, 26'h000_0010}, 1'b1, 1'b0, 1'b0);
        do_instr(1, 0, {16'h1000, 16'hFFFE}, 1'b0, 1'b1, 1'b0);
        checks++; if (imem_addr !== 32'h44) begin failures++; $display("FAIL br_not_taken got=%h exp=%h", imem_addr, 32'h44); end
    endtask

    task automatic test_jump();
        force dut.pc = 32'h1000_0010;
        #1;
        release dut.pc;
        mpc = 32'h1000_0010;
        checks++; if (imem_addr !== 32'h1000_0010) begin failures++; $display("FAIL jmp_setup got=%h exp=%h", imem_addr, 32'h1000_0010); end
        do_instr(0, 0, {6'h02, 26'h000_0100}, 1'b1, 1'b1, 1'b1);
        checks++; if (imem_addr !== 32'h1000_0400) begin failures++; $display("FAIL jmp_priority got=%h exp=%h", imem_addr, 32'h1000_0400); end
    endtask

    task automatic test_stalls();
        logic [31:0] a;
        logic [31:0] w;
        a = imem_addr;
        w = $urandom;
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin imem_ack = 1'b1; imem_rdata = w; end
            else imem_rdata = $urandom;
            checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin failures++; $display("FAIL stall_req%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, a); end
            @(posedge clk); @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            imem_ack = (i < 2);
            imem_rdata = $urandom;
            instr_ready = (i == 2);
            checks++; if (instr_valid !== 1'b1 || instr !== w) begin failures++; $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", i, instr_valid, instr, w); end
            checks++; if (imem_req !== 1'b0 || retire_cnt !== mcnt) begin failures++; $display("FAIL stall_cnt%0d got=%b/%0d exp=0/%0d", i, imem_req, retire_cnt, mcnt); end
            @(posedge clk); @(negedge clk);
        end
        instr_ready = 1'b0;
        imem_ack = 1'b0;
        mpc = model_next(mpc, w, 1'b0, 1'b0, 1'b0);
        mcnt = mcnt + 32'd1;
        checks++; if (retire_cnt !== mcnt || imem_addr !== mpc || imem_req !== 1'b1) begin failures++; $display("FAIL stall_retire got=%0d/%h exp=%0d/%h", retire_cnt, imem_addr, mcnt, mpc); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        j, b, z;
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            j = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 1) == 0);
            z = 1'($urandom);
            do_instr($urandom_range(0, 2), $urandom_range(0, 2), w, j, b, z);
            checks++; if (imem_addr !== mpc || imem_addr[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_addr%0d got=%h exp=%h", i, imem_addr, mpc); end
            checks++; if (pc_plus4 !== mpc + 32'd4) begin failures++; $display("FAIL rnd_pc4_%0d got=%h exp=%h", i, pc_plus4, mpc + 32'd4); end
            checks++; if (retire_cnt !== mcnt || instr !== w) begin failures++; $display("FAIL rnd_state%0d got=%0d/%h exp=%0d/%h", i, retire_cnt, instr, mcnt, w); end
        end
    endtask

    task automatic test_reset_mid();
        do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0);
        imem_rdata = $urandom;
        imem_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0 || instr !== 32'd0) begin failures++; $display("FAIL rst_fetch got=%b/%h/%h exp=0/0/0", imem_req, imem_addr, instr); end
        checks++; if (retire_cnt !== 32'd0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rst_fetch_cnt got=%0d/%b exp=0/0", retire_cnt, instr_valid); end
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        mpc = 32'd0; mcnt = 32'd0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin failures++; $display("FAIL rst_fetch_restart got=%b/%h exp=1/0", imem_req, imem_addr); end
        do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0);
        imem_rdata = $urandom;
        imem_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0;
        instr_ready = 1'b1; jump_f = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || pc !== 32'd0 || pc_plus4 !== 32'd4) begin failures++; $display("FAIL rst_hold got=%b/%h/%h exp=0/0/4", instr_valid, pc, pc_plus4); end
        checks++; if (retire_cnt !== 32'd0 || instr !== 32'd0) begin failures++; $display("FAIL rst_hold_cnt got=%0d/%h exp=0/0", retire_cnt, instr); end
        @(negedge clk);
        instr_ready = 1'b0; jump_f = 1'b0;
        rst_n = 1'b1;
        mpc = 32'd0; mcnt = 32'd0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || retire_cnt !== 32'd0) begin failures++; $display("FAIL rst_hold_restart got=%b/%h/%0d exp=1/0/0", imem_req, imem_addr, retire_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        do_instr(0, 0, {16'h1000, 16'hFFFE}, 1'b0, 1'b1, 1'b1);
        checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0) begin failures++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/0", imem_addr, pc_plus4); end
        do_instr(0, 0, $urandom, 1'b0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'd0 || imem_addr !== mpc) begin failures++; $display("FAIL wrap_pc got=%h exp=0", imem_addr); end
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        mcnt = 32'hFFFF_FFFF;
        do_instr(1, 1, $urandom, 1'b0, 1'b0, 1'b0);
        checks++; if (retire_cnt !== 32'd0 || retire_cnt !== mcnt) begin failures++; $display("FAIL wrap_cnt got=%h exp=0", retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stalls();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
